fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single FIFO write port among NUM_REQ requesters. It sits between the producers and the FIFO. It issues one FIFO write at a time and confirms each write with the FIFO's registered `wr_ack`/`overflow` response. A write is acknowledged to its requester only when the FIFO has accepted it. A rejected write (overflow) is retried automatically, and the same requester keeps top priority.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `FIFO_WIDTH`, 16, data width; matches the FIFO's `FIFO_WIDTH`
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  NUM_REQ  per-requester write request; held high with stable data until its `grant` pulse
- `req_data`  in  NUM_REQ*FIFO_WIDTH  requester i's data at bits [i*FIFO_WIDTH +: FIFO_WIDTH]
- `grant`  out  NUM_REQ  one-hot, one-cycle pulse: requester's word accepted by the FIFO
- `busy`  out  1  a write is in flight (state ≠ IDLE)
- `overflow_cnt`  out  8  saturating count of FIFO-rejected writes
- `wr_en`  out  1  to FIFO `wr_en`
- `data_in`  out  FIFO_WIDTH  to FIFO `data_in`
- `wr_ack`  in  1  from FIFO; registered, valid the cycle after the `wr_en` sampling edge
- `overflow`  in  1  from FIFO; same timing as `wr_ack`
- `full`  in  1  from FIFO

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE:**
  - If `|req && !full`: pick the winner round-robin, starting the search at `ptr` and continuing `ptr+1`, … modulo NUM_REQ.
  - Register `owner`, `data_in = req_data[owner]` and `wr_en = 1`, then go to ISSUE.
  - Otherwise stay in IDLE with `wr_en = 0`.
- **ISSUE:**
  - `wr_en` is high for exactly this cycle.
  - Next edge: `wr_en <= 0`, go to WAIT.
- **WAIT:** sample `wr_ack`/`overflow`, then go to IDLE.
  - `wr_ack = 1`: `grant[owner] <= 1` for one cycle; `ptr <= (owner+1) % NUM_REQ`.
  - `overflow = 1`: no grant; `ptr <= owner`; `overflow_cnt` increments, saturating at 255.
  - Neither asserted (e.g. FIFO reset): no grant; `ptr <= owner`; no count.
  - Both asserted: treated as `wr_ack` (FIFO fault; no count).
- `full` is checked only in IDLE. A write issued just as the FIFO fills resolves through the overflow/retry path.
- Requester drops `req` mid-transaction (protocol violation): the write still completes and `grant` still pulses.
- `data_in` holds its last value while `wr_en = 0`.
- Reset, asynchronous and applicable mid-transaction:
  - State returns to IDLE and `ptr` to 0.
  - `wr_en`, `grant`, `busy` go to 0; `data_in` to 0; `overflow_cnt` to 0.
  - Any in-flight write is abandoned with no grant.

## Timing
- Cycle 0 (IDLE): `req` and `full` sampled; winner chosen.
- Cycle 1 (ISSUE): `wr_en = 1` and `data_in` valid; the FIFO samples at the end of cycle 1.
- Cycle 2 (WAIT): `wr_ack`/`overflow` valid and sampled.
- Cycle 3: `grant` pulse; the FSM is back in IDLE and can arbitrate again in this same cycle.
- Throughput is one write per 3 cycles. Latency from `req` to `grant` is 3 cycles when uncontended and not full.
- `busy` is high in cycles 1–2. All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- `shared_pkg`:
  - `FIFO_WIDTH` constant
  - `arb_state_e` enum (IDLE, ISSUE, WAIT)
  - `OVF_CNT_W = 8`
- Sub-module `rr_picker`: purely combinational. Inputs `req` and `ptr`; outputs `valid` and a `winner` index. Implemented as a rotate, then fixed-priority pick, then un-rotate. Reusable for the read side.
- The top level holds the FSM, `ptr`, `owner`, output registers and the counter.

## Test plan
- Reset, then `req = 4'b0001`, `req_data[0] = 16'hA5A5`, `full = 0`, FIFO acks → `wr_en` high in cycle 1 with `data_in = A5A5`; `grant = 4'b0001` in cycle 3; `busy` high for 2 cycles.
- `req = 4'b1111` held, FIFO always acks → grants in order 0, 1, 2, 3, 0 every 3 cycles; no requester is granted twice in a row.
- `full = 1` with `req = 4'b0010` → `wr_en` stays 0 and `busy` 0. Deassert `full` → write issued on the next IDLE cycle; `grant[1]` 3 cycles later.
- FIFO returns `overflow` for requester 2 while `req = 4'b1100` → no grant; `overflow_cnt = 1`; next write again serves requester 2, not requester 3.
- 300 consecutive overflows → `overflow_cnt` saturates at 255.
- `rst_n` pulled low during ISSUE → `wr_en`, `grant` and `busy` drop immediately; after release, arbitration restarts at requester 0 with no stale grant.

Source files
------------

// File: rtl/shared_pkg.sv
// Shared types and constants for the FIFO write-side arbiter.
// The read-side arbiter can reuse the same state type and rr_picker.
package shared_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int OVF_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    // Saturating increment for the overflow statistics counter.
    function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] value);
        return (value == {OVF_CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: rotate the request vector so ptr sits at
// bit 0, take the lowest set bit, then map the offset back to a requester index.
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);

    logic [N-1:0]     rotated;
    logic [IDX_W-1:0] offset;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            logic [IDX_W-1:0] src;
            assign src         = IDX_W'((int'(ptr) + gi) % N);
            assign rotated[gi] = req[src];
        end
    endgenerate

    always_comb begin
        offset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset = IDX_W'(k);
            end
        end
    end

    assign valid  = |rotated;
    assign winner = IDX_W'((int'(ptr) + int'(offset)) % N);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Each write is confirmed by the FIFO's registered wr_ack/overflow before granting.
module fifo_wr_arbiter
    import shared_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = shared_pkg::FIFO_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic [OVF_CNT_W-1:0]          overflow_cnt,
    output logic                          wr_en,
    output logic [FIFO_WIDTH-1:0]         data_in,
    input  logic                          wr_ack,
    input  logic                          overflow,
    input  logic                          full
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e             state_reg, state_next;
    logic [IDX_W-1:0]       ptr_reg, ptr_next;
    logic [IDX_W-1:0]       owner_reg, owner_next;
    logic [FIFO_WIDTH-1:0]  data_reg, data_next;
    logic                   wr_en_reg, wr_en_next;
    logic                   busy_reg, busy_next;
    logic [NUM_REQ-1:0]     grant_reg, grant_next;
    logic [OVF_CNT_W-1:0]   cnt_reg, cnt_next;

    logic [FIFO_WIDTH-1:0]  req_word [NUM_REQ];
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_winner;
    logic [IDX_W-1:0]       owner_succ;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_word[gi] = req_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
        end
    endgenerate

    rr_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (req),
        .ptr    (ptr_reg),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    assign owner_succ = (int'(owner_reg) == NUM_REQ - 1) ? '0 : owner_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        data_next  = data_reg;
        cnt_next   = cnt_reg;
        wr_en_next = 1'b0;
        grant_next = '0;

        case (state_reg)
            IDLE: begin
                if (pick_valid && !full) begin
                    owner_next = pick_winner;
                    data_next  = req_word[pick_winner];
                    wr_en_next = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                state_next = IDLE;
                // A simultaneous ack+overflow is a FIFO fault; the ack wins.
                if (wr_ack) begin
                    grant_next[owner_reg] = 1'b1;
                    ptr_next              = owner_succ;
                end else begin
                    ptr_next = owner_reg;
                    if (overflow) begin
                        cnt_next = sat_inc(cnt_reg);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            owner_reg <= '0;
            data_reg  <= '0;
            wr_en_reg <= 1'b0;
            busy_reg  <= 1'b0;
            grant_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
            data_reg  <= data_next;
            wr_en_reg <= wr_en_next;
            busy_reg  <= busy_next;
            grant_reg <= grant_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign grant        = grant_reg;
    assign busy         = busy_reg;
    assign overflow_cnt = cnt_reg;
    assign wr_en        = wr_en_reg;
    assign data_in      = data_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_fifo_wr_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   grant;
    logic           busy;
    logic [7:0]     overflow_cnt;
    logic           wr_en;
    logic [W-1:0]   data_in;
    logic           wr_ack = 1'b0;
    logic           overflow = 1'b0;
    logic           full = 1'b0;

    // FIFO response mode for the write sampled at the next edge:
    // 0 ack, 1 overflow, 2 no response, 3 both asserted.
    int mode = 0;
    int vectors = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
        .grant        (grant),
        .busy         (busy),
        .overflow_cnt (overflow_cnt),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .wr_ack       (wr_ack),
        .overflow     (overflow),
        .full         (full)
    );

    // Emulated FIFO response: registered, valid the cycle after wr_en is sampled.
    always @(posedge clk) begin
        wr_ack   <= wr_en && (mode == 0 || mode == 3);
        overflow <= wr_en && (mode == 1 || mode == 3);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model, checked on every negedge -------------
    int           cyc = 0;
    int           m_ptr = 0;
    int           m_owner = 0;
    int           m_issue = -10;
    bit           m_inflight = 1'b0;
    int           m_cnt = 0;
    int           m_mode = 0;
    logic [W-1:0] m_data = '0;
    logic [W-1:0] m_pend = '0;
    logic [N-1:0] m_grant;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_ptr = 0; m_inflight = 1'b0; m_cnt = 0; m_data = '0;
            check("rst_wr_en", wr_en, 0);
            check("rst_busy", busy, 0);
            check("rst_grant", grant, 0);
            check("rst_data", data_in, 0);
            check("rst_cnt", overflow_cnt, 0);
        end else begin
            m_grant = '0;
            if (m_inflight && cyc == m_issue) begin
                m_data = m_pend;
                m_mode = mode;
            end
            if (m_inflight && cyc == m_issue + 2) begin
                if (m_mode == 0 || m_mode == 3) begin
                    m_grant[m_owner] = 1'b1;
                    m_ptr = (m_owner + 1) % N;
                end else begin
                    m_ptr = m_owner;
                    if (m_mode == 1 && m_cnt < 255) m_cnt++;
                end
                m_inflight = 1'b0;
            end
            check("wr_en", wr_en, {31'd0, m_inflight && cyc == m_issue});
            check("busy", busy, {31'd0, m_inflight && (cyc == m_issue || cyc == m_issue + 1)});
            check("grant", grant, m_grant);
            check("data_in", data_in, m_data);
            check("overflow_cnt", overflow_cnt, m_cnt);
            if (!m_inflight && req != 0 && !full) begin
                for (int k = 0; k < N; k++) begin
                    if (!m_inflight && req[(m_ptr + k) % N]) begin
                        m_owner    = (m_ptr + k) % N;
                        m_pend     = req_data[m_owner*W +: W];
                        m_issue    = cyc + 1;
                        m_inflight = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req = '0; full = 1'b0; mode = 0;
        rst_n = 1'b0;
        tick; tick;
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(output logic [N-1:0] g, output int cycles);
        g = '0;
        cycles = 0;
        while (g == 0 && cycles < 50) begin
            tick;
            cycles++;
            g = grant;
        end
        if (g == 0) begin
            vectors++;
            errors++;
            $display("FAIL grant_timeout: no grant within %0d cycles", cycles);
        end
    endtask

    logic [N-1:0] g;
    int           n;
    int           rr_exp [5] = '{0, 1, 2, 3, 0};
    int           words_left [N];
    int           r;

    initial begin
        #2 rst_n = 1'b0;
        tick;

        // Uncontended single write.
        do_reset;
        req = 4'b0001; req_data[0 +: W] = 16'hA5A5;
        check("d1_idle_wr_en", wr_en, 0);
        tick;
        check("d1_c1_wr_en", wr_en, 1);
        check("d1_c1_data", data_in, 16'hA5A5);
        check("d1_c1_busy", busy, 1);
        tick;
        check("d1_c2_wr_en", wr_en, 0);
        check("d1_c2_busy", busy, 1);
        tick;
        check("d1_c3_grant", grant, 4'b0001);
        check("d1_c3_busy", busy, 0);
        req = '0;
        tick;

        // All requesting: strict rotation, one grant every 3 cycles.
        do_reset;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(16'h1111 * (i + 1));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g, n);
            check("rr_order", g, 32'(1) << rr_exp[k]);
            check("rr_spacing", n, 3);
        end
        req = '0;
        tick; tick;

        // FIFO full blocks issue; release then issue.
        do_reset;
        full = 1'b1; req = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            tick;
            check("full_wr_en", wr_en, 0);
            check("full_busy", busy, 0);
        end
        full = 1'b0;
        wait_grant(g, n);
        check("full_grant", g, 4'b0010);
        check("full_latency", n, 3);
        req = '0;
        tick;

        // Overflow on requester 2 keeps it at top priority.
        do_reset;
        req_data[2*W +: W] = 16'h1234; req_data[3*W +: W] = 16'h5678;
        req = 4'b1100; mode = 1;
        tick;
        check("ovf_c1_data", data_in, 16'h1234);
        tick;
        mode = 0;
        tick;
        check("ovf_no_grant", grant, 0);
        check("ovf_cnt_one", overflow_cnt, 1);
        wait_grant(g, n);
        check("ovf_retry_owner", g, 4'b0100);
        req = '0;
        tick; tick;

        // Counter saturation.
        do_reset;
        req = 4'b0001; mode = 1;
        repeat (300 * 3 + 6) tick;
        check("ovf_saturate", overflow_cnt, 255);
        req = '0; mode = 0;
        repeat (4) tick;

        // Asynchronous reset during ISSUE.
        do_reset;
        req = 4'b1111;
        wait_grant(g, n);
        check("rst_pre_grant", g, 4'b0001);
        tick;
        check("rst_issue_wr_en", wr_en, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_wr_en", wr_en, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_grant", grant, 0);
        tick; tick;
        rst_n = 1'b1;
        wait_grant(g, n);
        check("rst_restart_owner", g, 4'b0001);
        check("rst_restart_latency", n, 3);
        req = '0;
        tick;

        // Randomized traffic against the model.
        do_reset;
        for (int i = 0; i < N; i++) words_left[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    if (words_left[i] > 0) words_left[i]--;
                    req_data[i*W +: W] = W'($urandom);
                end
                if (words_left[i] == 0 && $urandom_range(0, 7) == 0)
                    words_left[i] = $urandom_range(1, 4);
                req[i] = (words_left[i] != 0);
            end
            full = ($urandom_range(0, 5) == 0);
            r = $urandom_range(0, 9);
            mode = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                tick;
                rst_n = 1'b1;
            end else begin
                tick;
            end
        end
        req = '0;
        repeat (5) tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
